digit_serial_adder: RTL

Parametrised digit-serial adder/subtractor: two WIDTH-bit operands are processed DIGIT bits per clock through one shared DIGIT-bit ripple cell. It provides a cycle-accurate, area-reduced arithmetic unit for datapaths where latency is cheaper than a full-width carry chain. Operands enter and results leave through valid/ready handshakes.

---
 rtl/digit_serial_adder_pkg.sv | 16 +
 rtl/digit_serial_adder_cell.sv | 31 +++
 rtl/digit_serial_adder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// The FSM state encoding and the digit counter sizing live here.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // A single-digit configuration still needs a 1-bit counter.
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_cell.sv
// Combinational DIGIT-bit ripple adder, the only arithmetic cell of the serial adder.
// Exposes the carry into its top bit so the parent can form the signed overflow flag.
module digit_add_cell #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             carry_top
);

    logic c;

    // Ripple from bit 0 upward; the carry entering the top bit is captured on the way.
    always_comb begin
        sum       = '0;
        carry_top = 1'b0;
        c         = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                carry_top = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands are consumed DIGIT bits per clock
// through one shared ripple cell, with valid/ready handshakes on both sides.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = counter_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
            $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    count;
    logic             last_digit;

    logic [DIGIT-1:0] digit_sum;
    logic             digit_cout;
    logic             digit_ctop;

    digit_add_cell #(
        .DIGIT(DIGIT)
    ) u_cell (
        .a        (a_reg[DIGIT-1:0]),
        .b        (b_reg[DIGIT-1:0]),
        .cin      (carry),
        .sum      (digit_sum),
        .cout     (digit_cout),
        .carry_top(digit_ctop)
    );

    // New digits enter at the top so after N steps the first digit sits at bit 0.
    assign res_next   = (res_reg >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
    assign last_digit = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Subtraction is a + ~b + 1, so the inversion and the forced carry are applied at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            carry    <= 1'b0;
            count    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> DIGIT;
                    b_reg   <= b_reg >> DIGIT;
                    res_reg <= res_next;
                    carry   <= digit_cout;
                    count   <= count + CW'(1);
                    if (last_digit) begin
                        sum      <= res_next;
                        cout     <= digit_cout;
                        overflow <= digit_cout ^ digit_ctop;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
